// File: rtl/gate_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// gate_sweep_ctrl
//
// Self-test sequencer for a 2-input OR datapath (a, b -> c). A start request
// makes it drive the four input vectors 00, 01, 10, 11 in order. Each vector is
// held for HOLD_CYCLES cycles. On the last cycle of each hold window the
// returned c is compared with a|b. The block records which vectors failed,
// counts mismatches (saturating) and reports an overall pass flag.
//
// Parameters:
//   HOLD_CYCLES  cycles each vector is held (>= 1)
//   ERR_W        width of err_count
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      sweep request, only acted on while idle
//   a, b       registered drive to the datapath inputs
//   c          datapath output under test
//   busy       high while a sweep is in progress
//   done       one-cycle pulse when a sweep completes
//   pass       last completed sweep had zero mismatches
//   err_count  mismatch count of the last/current sweep (saturating)
//   fail_vec   bit i set when vector i ({a,b} == i) mismatched
// ----------------------------------------------------------------------------
module gate_sweep_ctrl #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned ERR_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    // A 1-bit counter is kept even for HOLD_CYCLES == 1; it simply stays at 0.
    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0]  CntLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0]  CntOne  = CntW'(1);
    localparam logic [ERR_W-1:0] ErrMax  = '1;
    localparam logic [ERR_W-1:0] ErrOne  = ERR_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StFinish
    } state_e;

    state_e           state_q;
    logic [1:0]       idx_q;
    logic [CntW-1:0]  cnt_q;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_count_q;
    logic [3:0]       fail_vec_q;

    // Result update for the compare at the end of the current hold window.
    logic             window_end;
    logic             mismatch;
    logic [ERR_W-1:0] err_count_d;
    logic [3:0]       fail_vec_d;

    always_comb begin
        window_end  = (cnt_q == CntLast);
        mismatch    = (c != (a_q | b_q));
        err_count_d = err_count_q;
        fail_vec_d  = fail_vec_q;
        if (mismatch) begin
            fail_vec_d = fail_vec_q | (4'b0001 << idx_q);
            if (err_count_q != ErrMax) begin
                err_count_d = err_count_q + ErrOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            fail_vec_q  <= 4'b0000;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StDrive;
                        idx_q       <= 2'd0;
                        cnt_q       <= '0;
                        a_q         <= 1'b0;
                        b_q         <= 1'b0;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        err_count_q <= '0;
                        fail_vec_q  <= 4'b0000;
                    end
                end

                StDrive: begin
                    if (window_end) begin
                        err_count_q <= err_count_d;
                        fail_vec_q  <= fail_vec_d;
                        cnt_q       <= '0;
                        if (idx_q == 2'd3) begin
                            // Final compare is folded into pass so it is valid
                            // during the done cycle.
                            state_q <= StFinish;
                            idx_q   <= 2'd0;
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_d == '0);
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            {a_q, b_q} <= idx_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end

                StFinish: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_gate_sweep_ctrl
//
// Bench for gate_sweep_ctrl. Three instances: the default build (HOLD_CYCLES=10,
// ERR_W=3) with a selectable gate model on c, a HOLD_CYCLES=1 build with a
// correct OR gate, and a HOLD_CYCLES=1, ERR_W=1 build for saturation.
// ----------------------------------------------------------------------------
module tb_gate_sweep_ctrl;

    localparam int H = 10;

    // Gate models placed on c.
    localparam int MOr    = 0;
    localparam int MStk0  = 1;
    localparam int MAnd   = 2;
    localparam int MStk1  = 3;
    localparam int MInv   = 4;
    localparam int MXor   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance.
    logic       start, a, b, c, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
    int         mode;

    // HOLD_CYCLES=1 instance, correct OR.
    logic       start1, a1, b1, c1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fail1;

    // HOLD_CYCLES=1, ERR_W=1 instance.
    logic       start2, a2, b2, c2, busy2, done2, pass2;
    logic [0:0] err2;
    logic [3:0] fail2;
    int         mode2;

    int total = 0;
    int bad   = 0;

    function automatic logic model_c(input int m, input logic x, input logic y);
        case (m)
            MOr:     return x | y;
            MStk0:   return 1'b0;
            MAnd:    return x & y;
            MStk1:   return 1'b1;
            MInv:    return ~(x | y);
            MXor:    return x ^ y;
            default: return x | y;
        endcase
    endfunction

    always_comb c  = model_c(mode, a, b);
    always_comb c1 = a1 | b1;
    always_comb c2 = model_c(mode2, a2, b2);

    gate_sweep_ctrl #(.HOLD_CYCLES(H), .ERR_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
    );

    gate_sweep_ctrl #(.HOLD_CYCLES(1), .ERR_W(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
    );

    gate_sweep_ctrl #(.HOLD_CYCLES(1), .ERR_W(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c(c2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fail2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " a"}, 32'(a), 0);
        check({tag, " b"}, 32'(b), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " pass"}, 32'(pass), 0);
        check({tag, " err_count"}, 32'(err_count), 0);
        check({tag, " fail_vec"}, 32'(fail_vec), 0);
    endtask

    // Full sweep on the main instance with cycle-exact checks. pulse_at >= 0
    // pulses start during the sweep at that cycle offset.
    task automatic run_sweep(input int m, input logic [3:0] efv, input logic [2:0] eerr,
                             input logic epass, input int pulse_at);
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4 * H; i++) begin
            check("sweep busy", 32'(busy), 1);
            check("sweep done low", 32'(done), 0);
            check("sweep vector", 32'({a, b}), 32'(i / H));
            start = (i == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
        check("finish done", 32'(done), 1);
        check("finish busy", 32'(busy), 0);
        check("finish ab", 32'({a, b}), 0);
        check("finish pass", 32'(pass), 32'(epass));
        check("finish err_count", 32'(err_count), 32'(eerr));
        check("finish fail_vec", 32'(fail_vec), 32'(efv));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle done low", 32'(done), 0);
            check("idle busy", 32'(busy), 0);
            check("hold pass", 32'(pass), 32'(epass));
            check("hold err_count", 32'(err_count), 32'(eerr));
            check("hold fail_vec", 32'(fail_vec), 32'(efv));
        end
    endtask

    task automatic run_small2(input int m, input logic [3:0] efv, input logic eerr,
                              input logic epass);
        bit seen;
        mode2 = m;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done2) seen = 1'b1;
            else @(negedge clk);
        end
        check("dut2 done seen", 32'(seen), 1);
        check("dut2 err_count", 32'(err2), 32'(eerr));
        check("dut2 fail_vec", 32'(fail2), 32'(efv));
        check("dut2 pass", 32'(pass2), 32'(epass));
        @(negedge clk);
    endtask

    typedef struct {
        int         m;
        logic [3:0] fv;
        logic [2:0] err;
        logic       ps;
        int         pulse_at;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;

        vecs[0] = '{MOr,   4'b0000, 3'd0, 1'b1, -1};
        vecs[1] = '{MStk0, 4'b1110, 3'd3, 1'b0, -1};
        vecs[2] = '{MAnd,  4'b0110, 3'd2, 1'b0, -1};
        vecs[3] = '{MStk1, 4'b0001, 3'd1, 1'b0, -1};
        vecs[4] = '{MInv,  4'b1111, 3'd4, 1'b0, -1};
        vecs[5] = '{MXor,  4'b1000, 3'd1, 1'b0, -1};
        // start pulsed while vector 2 is driven: must be ignored.
        vecs[6] = '{MOr,   4'b0000, 3'd0, 1'b1, 2 * H + 3};

        rst = 1'b1; start = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode = MOr; mode2 = MOr;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_idle_zero("reset");

        for (int v = 0; v < 7; v++) begin
            run_sweep(vecs[v].m, vecs[v].fv, vecs[v].err, vecs[v].ps, vecs[v].pulse_at);
        end

        // Reset in sweep cycle 25 (vector 2 on the pins).
        mode = MStk0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        check("pre-reset vector", 32'({a, b}), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("mid-sweep reset");
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        check("no activity after reset", 32'(seen), 0);
        run_sweep(MOr, 4'b0000, 3'd0, 1'b1, -1);

        // Simultaneous rst and start: stay idle.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst beats start busy", 32'(busy), 0);
        @(negedge clk);
        check("rst beats start still idle", 32'(busy), 0);

        // start held high: back-to-back sweeps with one idle cycle between.
        mode = MOr;
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("held start first done", 32'(seen), 1);
        @(negedge clk);
        check("held start gap busy", 32'(busy), 0);
        check("held start gap done", 32'(done), 0);
        @(negedge clk);
        check("held start restart busy", 32'(busy), 1);
        check("held start restart ab", 32'({a, b}), 0);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("held start second done", 32'(seen), 1);
        check("held start second pass", 32'(pass), 1);

        // HOLD_CYCLES=1: busy for 4 cycles, done at k+5.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("h1 busy", 32'(busy1), 1);
            check("h1 vector", 32'({a1, b1}), 32'(i));
            check("h1 done low", 32'(done1), 0);
            @(negedge clk);
        end
        check("h1 done", 32'(done1), 1);
        check("h1 busy low", 32'(busy1), 0);
        check("h1 pass", 32'(pass1), 1);
        check("h1 fail_vec", 32'(fail1), 0);
        @(negedge clk);
        check("h1 done pulse one cycle", 32'(done1), 0);

        // ERR_W=1 saturation.
        run_small2(MStk1, 4'b0001, 1'b1, 1'b0);
        run_small2(MInv,  4'b1111, 1'b1, 1'b0);
        run_small2(MOr,   4'b0000, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Sequencer that exhaustively exercises a 2-input OR datapath (a, b -> c). On a start request it drives the four input vectors in order 00, 01, 10, 11, and holds each vector for a programmable number of cycles. On the last hold cycle of each vector it samples c and compares it against the expected a|b. It reports per-vector failures, an error count and a pass flag. It sits between the system-level self-test logic and the OR component instance, and it owns that component's inputs while a sweep runs.

Parameters:
HOLD_CYCLES, 10, cycles each vector is held; legal range >= 1
ERR_W, 3, width of err_count

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  sweep request, sampled in IDLE only
a  output  1  drive to datapath input a
b  output  1  drive to datapath input b
c  input  1  datapath output under test
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  1 when the last completed sweep had zero errors
err_count  output  ERR_W  number of mismatching vectors in the last/current sweep
fail_vec  output  4  bit i set when vector i mismatched (i = {a,b})

Behaviour:
- One clock domain. Reset is synchronous and active-high, named rst; clock is clk.
- Reset values: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vector index=0, hold counter=0.
- FSM states: IDLE, DRIVE, FINISH.
- IDLE:
  - a=b=0, busy=0.
  - start=1 at an edge: go to DRIVE; index=0, hold counter=0, err_count=0, fail_vec=0, pass=0.
- DRIVE:
  - busy=1; {a,b} = index (0:00, 1:01, 2:10, 3:11), all registered outputs.
  - Hold counter increments every cycle.
  - When counter == HOLD_CYCLES-1, c is compared with a|b at that edge.
  - On mismatch: set fail_vec[index] and increment err_count; err_count saturates at 2^ERR_W-1.
  - At the same edge: if index<3, increment index and clear the counter; else go to FINISH.
- FINISH (exactly one cycle):
  - done=1, busy=0, a=b=0.
  - pass = (err_count==0 including the final compare), registered so it is valid in this cycle.
  - Next state is IDLE unconditionally.
- Timing:
  - With start accepted at edge k, busy is high from k+1 for exactly 4*HOLD_CYCLES cycles.
  - done is high in cycle k+1+4*HOLD_CYCLES.
  - Vectors change only at hold-window boundaries.
- HOLD_CYCLES=1: each vector is sampled in the same cycle it is driven, so the datapath must be combinational (zero-latency).
- start in DRIVE or FINISH: ignored, with no queueing. start held high continuously: a new sweep begins on the first IDLE cycle after FINISH.
- Results (pass, err_count, fail_vec) remain stable in IDLE until the next accepted start clears them.
- c is treated as a single bit. X/Z on c is not handled specially; a compare against X counts as a mismatch only if simulation resolves it so.
- rst asserted mid-sweep: at the next edge, all state and outputs return to reset values. No done pulse is generated and partial results are discarded.
- Simultaneous rst and start: rst wins and the FSM stays in IDLE.

Test Plan:
1. Reset then idle 5 cycles -> a=b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0000.
2. Correct OR gate, HOLD_CYCLES=10, one-cycle start -> a,b step through 00,01,10,11 every 10 cycles. busy high for 40 cycles, then done pulses once with pass=1, err_count=0, fail_vec=0000.
3. c tied to 0 (stuck-at-0) -> fail_vec=1110, err_count=3, pass=0. An AND gate substituted for the OR -> fail_vec=0110, err_count=2, pass=0.
4. start pulsed during vector 2 of an active sweep -> no restart, done occurs at the original cycle, exactly one done pulse. start held high -> back-to-back sweeps separated by one IDLE cycle.
5. rst asserted at cycle 25 of a sweep (vector 2 driven) -> next cycle a=b=0, busy=0, no done, results zero. A following start runs a full clean sweep.
6. HOLD_CYCLES=1 build with a correct gate -> busy for 4 cycles, done at k+5, pass=1. Saturation check with ERR_W=1 and c stuck-at-1: only vector 0 fails, so err_count=1, fail_vec=0001; with c inverted, 4 failures saturate err_count at 1 and fail_vec=1111.
